// File: rtl/cmv300_spi_cfg_sequencer.sv
// cmv300_spi_cfg_sequencer: replays the CMV300 init table over the SPI engine, then serves host register accesses.
// Define CMV300_CFG_VERIFY_EN to read back every table write and count mismatches on verify_errs.
module cmv300_spi_cfg_sequencer #(
   parameter int SETTLE_CYC  = 10000,
   parameter int TBL_AW      = 6,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [15:0]       tbl_data,
   input  logic              host_req,
   input  logic              host_rw,
   input  logic [6:0]        host_addr,
   input  logic [7:0]        host_wdata,
   output logic [7:0]        host_rdata,
   output logic              host_done,
   output logic              host_busy,
   output logic              init_done,
   output logic              err_timeout,
   output logic              spi_start,
   output logic              spi_rw,
   output logic [6:0]        spi_addr,
   output logic [7:0]        spi_wdata,
`ifdef CMV300_CFG_VERIFY_EN
   output logic [7:0]        verify_errs,
`endif
   input  logic [7:0]        spi_rdata,
   input  logic              spi_done
);
`ifdef CMV300_CFG_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [3:0] {SETTLE, FETCH, ISSUE_T, WAIT_T, VISSUE, VWAIT, READY, ISSUE_H, WAIT_H} state_t;

   state_t        state, nxt, adv;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;
   logic          ph, req_q, pend, waiting, to, fin, last, tbl_step;

   assign waiting   = state inside {WAIT_T, VWAIT, WAIT_H};
   // spi_done on the expiry cycle still counts as a normal completion
   assign to        = waiting && tcnt == TW'(TIMEOUT_CYC - 1) && !spi_done;
   assign fin       = spi_done || to;
   assign last      = &tbl_addr;
   assign adv       = last ? READY : FETCH;
   assign tbl_step  = fin && state == (VERIFY ? VWAIT : WAIT_T);
   assign spi_start = state inside {ISSUE_T, VISSUE, ISSUE_H};
   assign host_busy = pend;

   always_comb begin
      nxt = state;
      case (state)
         SETTLE:  if (scnt == SW'(SETTLE_CYC - 1)) nxt = FETCH;
         FETCH:   if (ph) nxt = tbl_data[15] ? ISSUE_T : READY;
         ISSUE_T: nxt = WAIT_T;
         WAIT_T:  if (fin) nxt = VERIFY ? VISSUE : adv;
         VISSUE:  nxt = VWAIT;
         VWAIT:   if (fin) nxt = adv;
         READY:   if (pend) nxt = ISSUE_H;
         ISSUE_H: nxt = WAIT_H;
         WAIT_H:  if (fin) nxt = READY;
         default: nxt = SETTLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SETTLE;
         scnt        <= '0;
         tcnt        <= '0;
         ph          <= 1'b0;
         req_q       <= 1'b0;
         pend        <= 1'b0;
         tbl_addr    <= '0;
         host_rdata  <= '0;
         host_done   <= 1'b0;
         init_done   <= 1'b0;
         err_timeout <= 1'b0;
         spi_rw      <= 1'b0;
         spi_addr    <= '0;
         spi_wdata   <= '0;
      end else begin
         state       <= nxt;
         scnt        <= state == SETTLE ? scnt + 1'b1 : '0;
         tcnt        <= spi_start ? TW'(1) : waiting ? tcnt + 1'b1 : '0;
         ph          <= state == FETCH && !ph;
         req_q       <= host_req;
         pend        <= (state == WAIT_H && fin) ? 1'b0 : pend | (host_req & ~req_q);
         host_done   <= state == WAIT_H && fin;
         init_done   <= init_done | (nxt == READY);
         err_timeout <= err_timeout | to;
         if (tbl_step && !last) tbl_addr <= tbl_addr + 1'b1;
         if (state == WAIT_H && spi_done && !spi_rw) host_rdata <= spi_rdata;
         // ph marks the cycle the ROM word for tbl_addr is valid
         if (state == FETCH && ph && tbl_data[15]) {spi_rw, spi_addr, spi_wdata} <= {1'b1, tbl_data[14:0]};
         else if (state == READY && pend) {spi_rw, spi_addr, spi_wdata} <= {host_rw, host_addr, host_wdata};
         else if (VERIFY && state == WAIT_T && fin) spi_rw <= 1'b0;
      end
   end

`ifdef CMV300_CFG_VERIFY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) verify_errs <= '0;
      else if (state == VWAIT && fin && (to || spi_rdata != spi_wdata) && verify_errs != 8'hFF) verify_errs <= verify_errs + 1'b1;
   end
`endif
endmodule
